multicycle_maindec: RTL

MULTICYCLE_MAINDEC -- requirements
Module: multicycle_maindec

---
 rtl/multicycle_maindec_if.sv | 32 +++
 rtl/multicycle_maindec.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec_if.sv
// Control bundle between the multicycle main decoder and its datapath.
// The decoder sits on the slave side: it reads op and mem_ready and drives every control line.
interface multicycle_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state;

    modport slave (
        input  op, mem_ready,
        output pcwrite, irwrite, regwrite, memwrite, branch, iord, alusrca,
               regdst, memtoreg, alusrcb, pcsrc, aluop, illegal_op, state
    );

    modport master (
        output op, mem_ready,
        input  pcwrite, irwrite, regwrite, memwrite, branch, iord, alusrca,
               regdst, memtoreg, alusrcb, pcsrc, aluop, illegal_op, state
    );
endinterface

// File: rtl/multicycle_maindec.sv
// Moore-style main control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Outputs depend on state only, except the FETCH write enables (gated by mem_ready) and illegal_op.
module multicycle_maindec (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_maindec_if.slave    bus
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // op is stable from DECODE on, so anything other than lw/sw here is unreachable
            MEMADR: begin
                if (bus.op == OP_LW)
                    state_d = MEMRD;
                else if (bus.op == OP_SW)
                    state_d = MEMWR;
                else
                    state_d = FETCH;
            end
            MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // rst_n gates the FETCH enables so a ready memory cannot fire writes while reset is held
    always_comb begin
        bus.pcwrite    = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regwrite   = 1'b0;
        bus.memwrite   = 1'b0;
        bus.branch     = 1'b0;
        bus.iord       = 1'b0;
        bus.alusrca    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.aluop      = 2'b00;
        bus.illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.pcwrite = bus.mem_ready & rst_n;
                bus.irwrite = bus.mem_ready & rst_n;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: bus.illegal_op = 1'b0;
                    default:                                       bus.illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JUMP: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule
